// File: rtl/lab3_universal_shift_register.sv
// Universal shift register: hold, shift right, shift left or parallel load, with
// complement/serial taps and a one-cycle-delayed pattern-match flag.
module lab3_universal_shift_register #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             sin_msb,
  input  logic             sin_lsb,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] pattern,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] NQ,
  output logic             sout_lsb,
  output logic             sout_msb,
  output logic             match
);

  localparam logic [1:0] ModeHold  = 2'b00;
  localparam logic [1:0] ModeRight = 2'b01;
  localparam logic [1:0] ModeLeft  = 2'b10;
  localparam logic [1:0] ModeLoad  = 2'b11;

  logic [WIDTH-1:0] q_q, q_d;
  logic             match_q, match_d;

  // mode is only decoded under enable so an undriven mode cannot disturb a hold.
  always_comb begin
    q_d = q_q;
    if (enable) begin
      unique case (mode)
        ModeHold:  q_d = q_q;
        ModeRight: q_d = {sin_msb, q_q[WIDTH-1:1]};
        ModeLeft:  q_d = {q_q[WIDTH-2:0], sin_lsb};
        ModeLoad:  q_d = D;
        default:   q_d = q_q;
      endcase
    end
  end

  // Compares the pre-edge contents, so the flag trails Q by one clock.
  always_comb begin
    match_d = (q_q == pattern);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q_q     <= '0;
      match_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      match_q <= match_d;
    end
  end

  always_comb begin
    Q        = q_q;
    NQ       = ~q_q;
    sout_lsb = q_q[0];
    sout_msb = q_q[WIDTH-1];
    match    = match_q;
  end

endmodule

// File: tb/tb_lab3_universal_shift_register.sv
// Directed bench for lab3_universal_shift_register (WIDTH=4) with hand-computed
// expectations checked by immediate assertions.
module tb_lab3_universal_shift_register;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic [1:0] mode;
  logic       sin_msb;
  logic       sin_lsb;
  logic [3:0] D;
  logic [3:0] pattern;
  logic [3:0] Q;
  logic [3:0] NQ;
  logic       sout_lsb;
  logic       sout_msb;
  logic       match;

  int total = 0;
  int bad   = 0;

  lab3_universal_shift_register #(
    .WIDTH(4)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (enable),
    .mode    (mode),
    .sin_msb (sin_msb),
    .sin_lsb (sin_lsb),
    .D       (D),
    .pattern (pattern),
    .Q       (Q),
    .NQ      (NQ),
    .sout_lsb(sout_lsb),
    .sout_msb(sout_msb),
    .match   (match)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    mode    = 2'b00;
    sin_msb = 1'b0;
    sin_lsb = 1'b0;
    D       = 4'h0;
    pattern = 4'h0;
    #3;
    check("rst_q", 16'(Q), 16'h0);
    check("rst_nq", 16'(NQ), 16'hF);
    check("rst_match", 16'(match), 16'h0);
    check("rst_sout_lsb", 16'(sout_lsb), 16'h0);
    check("rst_sout_msb", 16'(sout_msb), 16'h0);

    // Edges during reset must be ignored even with a load requested.
    enable = 1'b1; mode = 2'b11; D = 4'hF;
    step();
    check("rst_edge_q", 16'(Q), 16'h0);
    check("rst_edge_match", 16'(match), 16'h0);

    // First edge after release with pattern=0: match rises.
    reset_n = 1'b1; enable = 1'b0; mode = 2'b00;
    step();
    check("post_rst_match", 16'(match), 16'h1);
    check("post_rst_q", 16'(Q), 16'h0);

    // Load A, then async reset mid-cycle.
    enable = 1'b1; mode = 2'b11; D = 4'hA;
    step();
    check("load_a_q", 16'(Q), 16'hA);
    check("load_a_match", 16'(match), 16'h1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_q", 16'(Q), 16'h0);
    check("async_rst_nq", 16'(NQ), 16'hF);
    check("async_rst_match", 16'(match), 16'h0);
    #1 reset_n = 1'b1;

    // Load then shift right with sin_msb=0.
    pattern = 4'hF;
    mode = 2'b11; D = 4'b1011;
    step();
    check("load_1011_q", 16'(Q), 16'b1011);
    check("load_1011_nq", 16'(NQ), 16'b0100);
    mode = 2'b01; sin_msb = 1'b0;
    step(); check("shr1_q", 16'(Q), 16'b0101); check("shr1_lsb", 16'(sout_lsb), 16'h1);
    step(); check("shr2_q", 16'(Q), 16'b0010); check("shr2_lsb", 16'(sout_lsb), 16'h0);
    step(); check("shr3_q", 16'(Q), 16'b0001); check("shr3_lsb", 16'(sout_lsb), 16'h1);
    step(); check("shr4_q", 16'(Q), 16'b0000); check("shr4_lsb", 16'(sout_lsb), 16'h0);

    // Shift right inserting ones at the MSB.
    sin_msb = 1'b1;
    step(); check("shr_in1_q", 16'(Q), 16'b1000); check("shr_in1_msb", 16'(sout_msb), 16'h1);
    mode = 2'b11; D = 4'h0;
    step(); check("clr_q", 16'(Q), 16'h0);

    // Shift left with sin_lsb=1.
    mode = 2'b10; sin_lsb = 1'b1;
    step(); check("shl1_q", 16'(Q), 16'b0001); check("shl1_msb", 16'(sout_msb), 16'h0);
    step(); check("shl2_q", 16'(Q), 16'b0011); check("shl2_msb", 16'(sout_msb), 16'h0);
    step(); check("shl3_q", 16'(Q), 16'b0111); check("shl3_msb", 16'(sout_msb), 16'h0);
    step(); check("shl4_q", 16'(Q), 16'b1111); check("shl4_msb", 16'(sout_msb), 16'h1);
    check("shl4_nq", 16'(NQ), 16'h0);
    check("shl4_match", 16'(match), 16'h0);
    step(); check("shl5_match", 16'(match), 16'h1);

    // Hold via enable=0 and via mode=00.
    mode = 2'b11; D = 4'b0110;
    step(); check("load_0110_q", 16'(Q), 16'b0110);
    enable = 1'b0; mode = 2'b11; D = 4'b1111;
    step(); check("hold_en1_q", 16'(Q), 16'b0110);
    step(); check("hold_en2_q", 16'(Q), 16'b0110);
    step(); check("hold_en3_q", 16'(Q), 16'b0110);
    enable = 1'b1; mode = 2'b00;
    step(); check("hold_mode_q", 16'(Q), 16'b0110);

    // Match lags Q by one clock.
    pattern = 4'b1001; mode = 2'b11; D = 4'b1001;
    step(); check("match_n_q", 16'(Q), 16'b1001); check("match_n", 16'(match), 16'h0);
    mode = 2'b01; sin_msb = 1'b0;
    step(); check("match_n1_q", 16'(Q), 16'b0100); check("match_n1", 16'(match), 16'h1);
    mode = 2'b00;
    step(); check("match_n2", 16'(match), 16'h0);

    // Reset pulse in the middle of a left-shift sequence.
    pattern = 4'hF; mode = 2'b11; D = 4'h0;
    step();
    mode = 2'b10; sin_lsb = 1'b1;
    step(); check("mid_shl1_q", 16'(Q), 16'b0001);
    step(); check("mid_shl2_q", 16'(Q), 16'b0011);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_q", 16'(Q), 16'h0);
    check("mid_rst_nq", 16'(NQ), 16'hF);
    check("mid_rst_msb", 16'(sout_msb), 16'h0);
    check("mid_rst_lsb", 16'(sout_lsb), 16'h0);
    #1 reset_n = 1'b1;
    step(); check("post_mid_rst_q", 16'(Q), 16'b0001);
    check("post_mid_rst_nq", 16'(NQ), 16'b1110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
